// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants and helpers for the select-and-add datapath
package arith_pkg;

  // Operand select encoding: which candidate becomes the second operand
  localparam logic SEL_B = 1'b0;
  localparam logic SEL_C = 1'b1;

  // Arithmetic mode encoding
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Legal pipeline depth: two stages are needed for operand capture and compute
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 16;

  // Result carries one extra bit so an add of two W-bit values never overflows
  function automatic int res_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one pipeline register with valid bit, stall enable and async clear
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  // Hold everything while stalled; data only moves with a valid sample so the
  // output keeps the last real result across bubbles
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  // Stage register; reset aborts whatever sample is held here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sel_add_pipe.sv
// rtl/sel_add_pipe.sv - pipelined select-and-add/subtract unit with valid/ready flow control
module sel_add_pipe
  import arith_pkg::*;
#(
  parameter int W      = 12,
  parameter int STAGES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  input  logic [W-1:0]            c,
  input  logic                    sel,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [res_width(W)-1:0] y
);

  localparam int RW  = res_width(W);
  // Stage 1 bundle: {sub, sel, c, b, a}
  localparam int OPW = 3 * W + 2;

  logic              advance;
  logic [STAGES-1:0] stg_valid;
  logic [OPW-1:0]    op_in;
  logic [OPW-1:0]    op_s1;
  logic [RW-1:0]     res_bus [1:STAGES-1];

  logic [W-1:0]      s1_a;
  logic [W-1:0]      s1_b;
  logic [W-1:0]      s1_c;
  logic              s1_sel;
  logic              s1_sub;
  logic [W-1:0]      s1_x;
  logic [RW-1:0]     res_s2_d;

  // Single global stall: the only thing that can stop the pipe is a result
  // sitting at the output that the consumer is not taking
  always_comb begin
    advance  = !(out_valid && !out_ready);
    in_ready = advance;
  end

  assign op_in = {sub, sel, c, b, a};

  assign s1_a   = op_s1[W-1:0];
  assign s1_b   = op_s1[2*W-1:W];
  assign s1_c   = op_s1[3*W-1:2*W];
  assign s1_sel = op_s1[3*W];
  assign s1_sub = op_s1[3*W+1];

  // Mux and add/sub between stage 1 and stage 2; both operands are
  // zero-extended so subtraction wraps modulo 2^(W+1)
  always_comb begin
    s1_x = (s1_sel == SEL_C) ? s1_c : s1_b;
    if (s1_sub == OP_SUB) begin
      res_s2_d = {1'b0, s1_a} - {1'b0, s1_x};
    end else begin
      res_s2_d = {1'b0, s1_a} + {1'b0, s1_x};
    end
  end

  // Stage 0 holds raw operands, stage 1 the computed result, the rest delay it
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_operands
      pipe_stage #(.DW(OPW)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .valid_i (in_valid),
        .data_i  (op_in),
        .valid_o (stg_valid[0]),
        .data_o  (op_s1)
      );
    end else if (i == 1) begin : g_compute
      pipe_stage #(.DW(RW)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .valid_i (stg_valid[0]),
        .data_i  (res_s2_d),
        .valid_o (stg_valid[1]),
        .data_o  (res_bus[1])
      );
    end else begin : g_delay
      pipe_stage #(.DW(RW)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .valid_i (stg_valid[i-1]),
        .data_i  (res_bus[i-1]),
        .valid_o (stg_valid[i]),
        .data_o  (res_bus[i])
      );
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign y         = res_bus[STAGES-1];

endmodule
